fb_cfg_loader: RTL and testbench

// - Serial configuration controller for a chain of fb_* cells (config_cell chain: config_clk/config_reset/config_in -> config_out).
// - Accepts config words over a valid/ready stream, optionally pulses config_reset, then shifts CHAIN_LEN bits LSB-first into the chain.
// - Sits between the host/config-memory interface and the head of the fabric config chain; one loader per chain.

---
 rtl/fb_cfg_loader.sv | 173 +++++++++++++++++
 tb/tb_fb_cfg_loader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_cfg_loader.sv
// Serial configuration loader for an fb_* config-cell chain: takes words over valid/ready and shifts
// CHAIN_LEN bits LSB-first into the chain. Optional readback of the chain tail under FB_CFG_READBACK_EN.
module fb_cfg_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              start_clr,
  output logic              busy,
  output logic              done,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              config_clk,
  output logic              config_reset,
  output logic              config_in,
  input  logic              config_tail,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int CNT_W  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int BIDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WAIT_WORD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_phase;
  logic                r_clr_cnt;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [BIDX_W-1:0]   r_bidx;
  logic [BIDX_W-1:0]   w_bidx_inc;
  logic [WORD_W-1:0]   r_word;
  logic                r_config_clk;
  logic                r_config_reset;
  logic                r_config_in;
  logic                w_hs;
  logic                w_last_bit;
  logic                w_word_end;

  assign w_hs       = (r_state == S_WAIT_WORD) && cfg_valid;
  assign w_last_bit = (r_bit_cnt == LAST_BIT);
  assign w_word_end = (r_bidx == LAST_IDX);
  assign w_bidx_inc = r_bidx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (start) w_state_nxt = start_clr ? S_CLR : S_WAIT_WORD;
      S_CLR:       if (r_clr_cnt) w_state_nxt = S_WAIT_WORD;
      S_WAIT_WORD: if (w_hs) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (r_phase) begin
          if (w_last_bit)      w_state_nxt = S_DONE;
          else if (w_word_end) w_state_nxt = S_WAIT_WORD;
        end
      end
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Chain outputs are registered so each bit sits stable on config_in across the config_clk rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_phase        <= 1'b0;
      r_clr_cnt      <= 1'b0;
      r_bit_cnt      <= '0;
      r_bidx         <= '0;
      r_config_clk   <= 1'b0;
      r_config_reset <= 1'b0;
      r_config_in    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_clr_cnt      <= (r_state == S_CLR) ? ~r_clr_cnt : 1'b0;
      r_config_reset <= (w_state_nxt == S_CLR);
      case (r_state)
        S_IDLE: begin
          r_phase      <= 1'b0;
          r_bit_cnt    <= '0;
          r_bidx       <= '0;
          r_config_clk <= 1'b0;
          r_config_in  <= 1'b0;
        end
        S_WAIT_WORD: begin
          r_config_clk <= 1'b0;
          if (w_hs) begin
            r_config_in <= cfg_data[0];
            r_bidx      <= '0;
            r_phase     <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (!r_phase) begin
            r_phase      <= 1'b1;
            r_config_clk <= 1'b1;
          end else begin
            r_phase      <= 1'b0;
            r_config_clk <= 1'b0;
            if (!w_last_bit) r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_last_bit || w_word_end) begin
              r_config_in <= 1'b0;
            end else begin
              r_bidx      <= w_bidx_inc;
              r_config_in <= r_word[w_bidx_inc];
            end
          end
        end
        default: begin
          r_config_clk <= 1'b0;
          r_config_in  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) r_word <= cfg_data;
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign cfg_ready    = (r_state == S_WAIT_WORD);
  assign config_clk   = r_config_clk;
  assign config_reset = r_config_reset;
  assign config_in    = r_config_in;

`ifdef FB_CFG_READBACK_EN
  logic [WORD_W-1:0] r_shadow;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              w_word_closed;

  assign w_word_closed = (r_state == S_SHIFT) && r_phase && (w_last_bit || w_word_end);

  // Tail is sampled on the edge that raises config_clk, i.e. before the chain shifts that bit out.
  always_ff @(posedge clk) begin
    if (w_hs) r_shadow <= '0;
    else if ((r_state == S_SHIFT) && !r_phase) r_shadow[r_bidx] <= config_tail;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_word_closed;
      if (w_word_closed) r_rd_data <= r_shadow;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
`else
  logic w_unused_tail;
  assign w_unused_tail = config_tail;
  assign rd_data       = '0;
  assign rd_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_fb_cfg_loader.sv
// Bench for fb_cfg_loader (WORD_W=32, CHAIN_LEN=40): cycle-level expected trace built from the
// protocol rules, a behavioural chain model driven by config_clk/config_reset, and literal pins.
module tb_fb_cfg_loader;

  localparam int WW = 32;
  localparam int CL = 40;
`ifdef FB_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          ready;
    logic          cclk;
    logic          creset;
    logic          cin;
    logic          rdv;
    logic [WW-1:0] rdd;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic          start_clr;
  logic          busy;
  logic          done;
  logic [WW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          config_clk;
  logic          config_reset;
  logic          config_in;
  logic          config_tail;
  logic [WW-1:0] rd_data;
  logic          rd_valid;

  fb_cfg_loader #(.WORD_W(WW), .CHAIN_LEN(CL)) dut (
    .clk(clk), .reset(reset), .start(start), .start_clr(start_clr),
    .busy(busy), .done(done), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .config_clk(config_clk), .config_reset(config_reset),
    .config_in(config_in), .config_tail(config_tail), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nprint = 0;

  // Behavioural chain: new bit enters at the head (bit CL-1), tail is bit 0.
  logic [CL-1:0] chain = '0;
  logic [CL-1:0] preload_val;
  logic          do_preload;
  int            edges = 0;

  always @(posedge config_clk or posedge config_reset or posedge do_preload) begin
    if (config_reset)    chain <= '0;
    else if (do_preload) chain <= preload_val;
    else begin
      chain <= {config_in, chain[CL-1:1]};
      edges <= edges + 1;
    end
  end
  assign config_tail = chain[0];

  exp_t          q[$];
  logic [WW-1:0] model_rd = '0;
  bit            pend = 1'b0;
  logic [WW-1:0] pend_data = '0;
  bit            chk_en = 1'b0;
  logic [WW-1:0] rd_seen[$];
  int            done_cnt = 0;
  int            creset_cnt = 0;

  function automatic exp_t outs();
    exp_t a;
    a = {busy, done, cfg_ready, config_clk, config_reset, config_in, rd_valid, rd_data};
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      exp_t a;
      if (q.size() > 0) e = q.pop_front();
      else e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_rd};
      a = outs();
      checks++;
      if (a !== e) begin
        errors++;
        if (nprint < 20)
          $display("FAIL cycle_outputs t=%0t: actual=%h required=%h", $time, a, e);
        nprint++;
      end
      if (rd_valid === 1'b1) rd_seen.push_back(rd_data);
      if (done === 1'b1) done_cnt++;
      if (config_reset === 1'b1) creset_cnt++;
    end
  end

  task automatic push(input logic b, input logic d, input logic r, input logic cc,
                      input logic cr, input logic ci);
    exp_t e;
    e.busy = b; e.done = d; e.ready = r; e.cclk = cc; e.creset = cr; e.cin = ci;
    e.rdv = 1'b0;
    if (pend) begin
      model_rd = pend_data;
      e.rdv    = 1'b1;
      pend     = 1'b0;
    end
    e.rdd = model_rd;
    q.push_back(e);
  endtask

  // Expected per-cycle outputs from the start cycle through DONE, for a given word/stall schedule.
  task automatic build_trace(input bit clr, input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                             input int st0, input int st1);
    logic [CL-1:0] snap;
    logic [WW-1:0] w[2];
    int            st[2];
    int            b;
    int            nb;
    w[0] = w0; w[1] = w1; st[0] = st0; st[1] = st1;
    snap = clr ? '0 : chain;
    push(0, 0, 0, 0, 0, 0);
    if (clr) begin
      push(1, 0, 0, 0, 1, 0);
      push(1, 0, 0, 0, 1, 0);
    end
    b = 0;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s <= st[k]; s++) push(1, 0, 1, 0, 0, 0);
      nb = (CL - b < WW) ? CL - b : WW;
      for (int j = 0; j < nb; j++) begin
        push(1, 0, 0, 0, 0, w[k][j]);
        push(1, 0, 0, 1, 0, w[k][j]);
      end
      if (RB) begin
        pend      = 1'b1;
        pend_data = '0;
        for (int j = 0; j < nb; j++) pend_data[j] = snap[b + j];
      end
      b += nb;
    end
    push(1, 1, 0, 0, 0, 0);
  endtask

  task automatic do_load(input bit clr, input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                         input int st0, input int st1, input bit junk, input bit poke);
    logic [WW-1:0] w[2];
    int            st[2];
    int            e0;
    int            n;
    bit            ok;
    logic [CL-1:0] exp_chain;
    logic [CL-1:0] snap;
    w[0] = w0; w[1] = w1; st[0] = st0; st[1] = st1;
    ok = 1'b1;
    @(posedge clk); #1;
    e0 = edges;
    snap = clr ? '0 : chain;
    for (int i = 0; i < CL; i++) exp_chain[i] = w[i / WW][i % WW];
    done_cnt = 0; creset_cnt = 0; rd_seen.delete();
    build_trace(clr, w0, w1, st0, st1);
    start = 1'b1; start_clr = clr;
    @(posedge clk); #1;
    start = 1'b0; start_clr = 1'($urandom);
    if (junk) begin
      cfg_valid = 1'b1;
      cfg_data  = $urandom;
    end
    for (int k = 0; k < 2 && ok; k++) begin
      n = 0;
      while (cfg_ready !== 1'b1 && n < 100) begin
        @(posedge clk); #1; n++;
      end
      if (cfg_ready !== 1'b1) begin
        check("ready_timeout", 64'(cfg_ready), 64'(1));
        ok = 1'b0;
      end else begin
        cfg_valid = 1'b0;
        repeat (st[k]) begin @(posedge clk); #1; end
        cfg_valid = 1'b1; cfg_data = w[k];
        @(posedge clk); #1;
        cfg_valid = 1'b0; cfg_data = $urandom;
        if (poke && k == 0) begin
          start = 1'b1; start_clr = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    end
    if (ok) begin
      n = 0;
      while (done !== 1'b1 && n < 300) begin
        @(posedge clk); #1; n++;
      end
      check("done_seen", 64'(done), 64'(1));
    end
    cfg_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("trace_consumed", 64'(q.size()), 64'(0));
    q.delete(); pend = 1'b0;
    check("edge_count", 64'(edges - e0), 64'(CL));
    check("chain_value", 64'(chain), 64'(exp_chain));
    check("done_pulses", 64'(done_cnt), 64'(1));
    check("busy_after", 64'(busy), 64'(0));
    if (clr) check("creset_cycles", 64'(creset_cnt), 64'(2));
`ifdef FB_CFG_READBACK_EN
    check("rd_count", 64'(rd_seen.size()), 64'(2));
    if (rd_seen.size() == 2) begin
      check("rd_word0", 64'(rd_seen[0]), 64'(snap[WW-1:0]));
      check("rd_word1", 64'(rd_seen[1]), 64'(snap[CL-1:WW]));
    end
`else
    check("rd_count", 64'(rd_seen.size()), 64'(0));
`endif
  endtask

  task automatic preload(input logic [CL-1:0] v);
    preload_val = v;
    do_preload  = 1'b1;
    #1;
    do_preload  = 1'b0;
  endtask

  initial begin
    logic [63:0] r64;
    clk = 1'b0; reset = 1'b0; start = 1'b0; start_clr = 1'b0;
    cfg_data = '0; cfg_valid = 1'b0; do_preload = 1'b0; preload_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'(outs()), 64'(0));
    reset = 1'b1;
    chk_en = 1'b1;

    // Clear + load, with cfg_valid asserted (junk) during CLR.
    do_load(1'b1, 32'hA5A5_0F0F, 32'h0000_00C3, 0, 0, 1'b1, 1'b0);
    check("clr_load_chain", 64'(chain), 64'h00_00C3_A5A5_0F0F);
    check("clr_load_creset", 64'(creset_cnt), 64'(2));

    // Backpressure on second word, with start pulsed during SHIFT.
    do_load(1'b0, 32'hA5A5_0F0F, 32'h0000_00C3, 0, 10, 1'b0, 1'b1);
    check("bp_chain", 64'(chain), 64'h00_00C3_A5A5_0F0F);

    // Partial last word: upper 24 bits must never be shifted.
    do_load(1'b0, 32'hA5A5_0F0F, 32'hFFFF_FF3C, 2, 1, 1'b0, 1'b0);
    check("partial_chain", 64'(chain), 64'h00_003C_A5A5_0F0F);

    // Readback of a preloaded chain.
    preload(40'h12_3456_789A);
    do_load(1'b0, 32'h1357_9BDF, 32'h0000_0024, 1, 0, 1'b0, 1'b0);
    check("rb_new_chain", 64'(chain), 64'h00_0024_1357_9BDF);
`ifdef FB_CFG_READBACK_EN
    if (rd_seen.size() == 2) begin
      check("rb_lit_word0", 64'(rd_seen[0]), 64'h3456_789A);
      check("rb_lit_word1", 64'(rd_seen[1]), 64'h0000_0012);
    end else begin
      check("rb_lit_count", 64'(rd_seen.size()), 64'(2));
    end
`endif

    // Reset in the middle of SHIFT.
    @(posedge clk); #1;
    chk_en = 1'b0; q.delete(); pend = 1'b0;
    done_cnt = 0;
    start = 1'b1; start_clr = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; cfg_valid = 1'b1; cfg_data = $urandom;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    repeat (21) begin @(posedge clk); #1; end
    check("busy_mid_shift", 64'(busy), 64'(1));
    check("clk_high_mid_shift", 64'(config_clk), 64'(1));
    reset = 1'b0;
    #1;
    check("reset_mid_shift", 64'(outs()), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_done_in_reset", 64'({done, busy}), 64'(0));
    end
    @(posedge clk); #1;
    reset = 1'b1;
    model_rd = '0;
    repeat (3) begin @(posedge clk); #1; end
    check("idle_after_abort", 64'(outs()), 64'(0));
    chk_en = 1'b1;
    do_load(1'b0, 32'hDEAD_BEEF, 32'h0000_0055, 0, 0, 1'b0, 1'b0);
    check("post_reset_chain", 64'(chain), 64'h00_0055_DEAD_BEEF);

    // Randomized loads.
    for (int t = 0; t < 10; t++) begin
      bit c;
      c = 1'($urandom);
      r64 = {$urandom, $urandom};
      preload(r64[CL-1:0]);
      do_load(c, $urandom, $urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
              c & 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
